// File: rtl/instr_encoder.sv
// RV32I instruction encoder (R-ALU, I-ALU, LOAD, STORE, BRANCH) with a small output FIFO and word-address counter.
// Optional macro ILLEGAL_CHECK_EN: consume illegal kinds, drop them and raise sticky err_illegal.
module instr_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_ZERO  = cnt_t'(0);
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t CNT_DEPTH = cnt_t'(FIFO_DEPTH);

    // Field packing for each supported class; anything else becomes the canonical NOP.
    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] b
    );
        logic [31:0] w;
        case (kind)
            3'd0:    w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            3'd1:    w = {b[11:0], rs1, f3, rd, 7'b0010011};
            3'd2:    w = {b[11:0], rs1, f3, rd, 7'b0000011};
            3'd3:    w = {b[11:5], rs2, rs1, f3, b[4:0], 7'b0100011};
            3'd4:    w = {b[11], b[9:4], rs2, rs1, f3, b[3:0], b[10], 7'b1100011};
            default: w = 32'h0000_0013;
        endcase
        return w;
    endfunction

    logic [31:0]       r_mem [FIFO_DEPTH];
    cnt_t              r_count;
    logic              r_out_valid;
    logic              r_in_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    logic [31:0]       w_mem_nxt [FIFO_DEPTH];
    logic [31:0]       w_word;
    cnt_t              w_count_nxt;
    cnt_t              w_wr_idx;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_legal;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_err_nxt;

    // Handshake decode, next FIFO contents (head always in slot 0), count and address.
    always_comb begin
        w_word = encode(in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
`ifdef ILLEGAL_CHECK_EN
        w_legal = (in_kind <= 3'd4);
`else
        w_legal = 1'b1;
`endif
        w_accept = in_valid & r_in_ready & ~addr_clr;
        w_push   = w_accept & w_legal;
        w_pop    = r_out_valid & out_ready & ~addr_clr;
        w_wr_idx = w_pop ? (r_count - CNT_ONE) : r_count;

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_mem_nxt[i] = r_mem[i];
        end
        if (w_pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                w_mem_nxt[i] = r_mem[i + 1];
            end
            w_mem_nxt[FIFO_DEPTH - 1] = 32'h0000_0000;
        end else begin
            w_mem_nxt[0] = w_mem_nxt[0];
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_push && (w_wr_idx == cnt_t'(i))) begin
                w_mem_nxt[i] = w_word;
            end else begin
                w_mem_nxt[i] = w_mem_nxt[i];
            end
        end

        if (addr_clr) begin
            w_count_nxt = CNT_ZERO;
            w_addr_nxt  = {ADDR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                w_mem_nxt[i] = 32'h0000_0000;
            end
        end else begin
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                w_count_nxt = r_count - CNT_ONE;
            end else begin
                w_count_nxt = r_count;
            end
            w_addr_nxt = w_pop ? (r_addr + ADDR_W'(1)) : r_addr;
        end

        // Illegal tuples only count as consumed when addr_clr is not dropping them.
        w_err_nxt = r_err | (w_accept & ~w_legal);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
            r_count     <= CNT_ZERO;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_addr      <= {ADDR_W{1'b0}};
            r_err       <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != CNT_ZERO);
            r_in_ready  <= (w_count_nxt < CNT_DEPTH);
            r_addr      <= w_addr_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign out_instr = r_mem[0];
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign out_addr  = r_addr;
`ifdef ILLEGAL_CHECK_EN
    assign err_illegal = r_err;
`else
    assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (ADDR_W=2 to exercise address wrap).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        addr_clr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [11:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_addr;
    logic        err_illegal;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_addr;

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(2)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_clr   (addr_clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        in_kind   = v.kind;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
    endtask

    // addi x1, x0, n
    task automatic drive_addi(input logic [11:0] n);
        in_kind   = 3'd1;
        in_funct3 = 3'd0;
        in_funct7 = 7'd0;
        in_rd     = 5'd1;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_imm    = n;
    endtask

    initial begin
        vecs[0] = '{3'd1, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0, 12'h005, 32'h00500093};
        vecs[1] = '{3'd0, 3'd0, 7'h00, 5'd3,  5'd1,  5'd2, 12'h000, 32'h002081B3};
        vecs[2] = '{3'd3, 3'd2, 7'h00, 5'd0,  5'd1,  5'd2, 12'h008, 32'h0020A423};
        vecs[3] = '{3'd4, 3'd0, 7'h00, 5'd0,  5'd1,  5'd2, 12'hFFE, 32'hFE208EE3};
        vecs[4] = '{3'd2, 3'd2, 7'h00, 5'd5,  5'd2,  5'd0, 12'h004, 32'h00412283};
        vecs[5] = '{3'd0, 3'd0, 7'h20, 5'd1,  5'd2,  5'd3, 12'h000, 32'h403100B3};
        vecs[6] = '{3'd1, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd9, 12'hFFF, 32'hFFFFFF93};
        vecs[7] = '{3'd3, 3'd0, 7'h55, 5'd17, 5'd0,  5'd0, 12'hFFF, 32'hFE000FA3};
        vecs[8] = '{3'd4, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0, 12'h800, 32'h80000063};
        vecs[9] = '{3'd0, 3'd0, 7'h00, 5'd3,  5'd1,  5'd2, 12'hFFF, 32'h002081B3};

        rst_n = 1'b0; addr_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_addi(12'h000);
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", {30'd0, out_addr}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_err", {31'd0, err_illegal}, 32'd0);
        rst_n = 1'b1;
        exp_addr = 2'd0;

        // Single-word encodes; addresses walk 0,1,2,3,0,... through the table.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp);
            check($sformatf("vec%0d_addr", i), {30'd0, out_addr}, {30'd0, exp_addr});
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_drain", i), {31'd0, out_valid}, 32'd0);
            exp_addr = exp_addr + 2'd1;
        end

        // Backpressure: fill, blocked third push, release in order.
        @(negedge clk);
        out_ready = 1'b0; drive_addi(12'd1); in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_1", {31'd0, in_ready}, 32'd1);
        check("bp_head_a", out_instr, 32'h00100093);
        drive_addi(12'd2);
        @(negedge clk);
        check("bp_full", {31'd0, in_ready}, 32'd0);
        drive_addi(12'd3);
        @(negedge clk);
        check("bp_still_full", {31'd0, in_ready}, 32'd0);
        check("bp_stable_instr", out_instr, 32'h00100093);
        check("bp_stable_addr", {30'd0, out_addr}, {30'd0, exp_addr});
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_word_b", out_instr, 32'h00200093);
        check("bp_addr_b", {30'd0, out_addr}, {30'd0, exp_addr + 2'd1});
        check("bp_ready_again", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("bp_word_c", out_instr, 32'h00300093);
        check("bp_addr_c", {30'd0, out_addr}, {30'd0, exp_addr + 2'd2});
        check("bp_valid_c", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_drain", {31'd0, out_valid}, 32'd0);
        exp_addr = exp_addr + 2'd3;

        // addr_clr with a full FIFO, then a second clear cycle that drops a ready tuple.
        out_ready = 1'b0; drive_addi(12'd4); in_valid = 1'b1;
        @(negedge clk);
        drive_addi(12'd5);
        @(negedge clk);
        check("clr_pre_full", {31'd0, in_ready}, 32'd0);
        check("clr_pre_addr", {30'd0, out_addr}, {30'd0, exp_addr});
        addr_clr = 1'b1; out_ready = 1'b1; drive_addi(12'd6);
        @(negedge clk);
        check("clr_valid", {31'd0, out_valid}, 32'd0);
        check("clr_ready", {31'd0, in_ready}, 32'd1);
        check("clr_addr", {30'd0, out_addr}, 32'd0);
        @(negedge clk);
        check("clr_drop", {31'd0, out_valid}, 32'd0);
        addr_clr = 1'b0; drive_addi(12'd7);
        @(negedge clk);
        check("clr_next_instr", out_instr, 32'h00700093);
        check("clr_next_addr", {30'd0, out_addr}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("clr_next_drain", {31'd0, out_valid}, 32'd0);
        exp_addr = 2'd1;

        // Illegal kind.
        drive_addi(12'd0); in_kind = 3'd6; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
`ifdef ILLEGAL_CHECK_EN
        check("ill_no_word", {31'd0, out_valid}, 32'd0);
        check("ill_err", {31'd0, err_illegal}, 32'd1);
        check("ill_ready", {31'd0, in_ready}, 32'd1);
`else
        check("ill_nop_valid", {31'd0, out_valid}, 32'd1);
        check("ill_nop_instr", out_instr, 32'h00000013);
        check("ill_nop_addr", {30'd0, out_addr}, {30'd0, exp_addr});
        check("ill_err_tied", {31'd0, err_illegal}, 32'd0);
        exp_addr = exp_addr + 2'd1;
`endif
        in_valid = 1'b0;
        @(negedge clk);
        drive_addi(12'd8); in_valid = 1'b1;
        @(negedge clk);
        check("ill_after_instr", out_instr, 32'h00800093);
        check("ill_after_addr", {30'd0, out_addr}, {30'd0, exp_addr});
`ifdef ILLEGAL_CHECK_EN
        check("ill_err_sticky", {31'd0, err_illegal}, 32'd1);
`else
        check("ill_err_zero", {31'd0, err_illegal}, 32'd0);
`endif
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2_err", {31'd0, err_illegal}, 32'd0);
        check("rst2_addr", {30'd0, out_addr}, 32'd0);
        check("rst2_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
